// File: rtl/reservation_station.sv
`timescale 1ns/1ps
// Output payload types for the reservation station.
package reservation_station_pkg;
    localparam int unsigned RS_XLEN = 32;

    // Scheduler view of one entry.
    typedef struct packed {
        logic               valid_operands;
        logic [2:0]         ALU_op;
        logic [3:0]         ROB_entry;
        logic [1:0]         branch_type;
        logic [RS_XLEN-1:0] rs1;
        logic [RS_XLEN-1:0] rs2;
    } rs_out_t;
endpackage

// reservation_station: four-entry RS bank for the integer/branch cluster.
// Accepts one dispatch per cycle into the lowest free entry, captures operands
// from the CDB (including same-cycle bypass at dispatch), and frees entries
// when the scheduler flags them on consumed_bus.
// Ports:
//   clk, reset (sync, active-high), flush (squash all entries)
//   disp_*       : dispatch request, opcode/ROB/branch info, operand rdy/val/tag
//   disp_ready   : combinational, high while at least one entry is free
//   cdb_*        : common data bus broadcast (valid/tag/value)
//   rs0..rs3_data: per-entry view for the scheduler
//   consumed_bus : bit i frees entry i at the next edge
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            disp_valid,
    input  logic [2:0]      disp_ALU_op,
    input  logic [3:0]      disp_ROB_entry,
    input  logic [1:0]      disp_branch_type,
    input  logic            disp_src1_rdy,
    input  logic            disp_src2_rdy,
    input  logic [XLEN-1:0] disp_src1_val,
    input  logic [XLEN-1:0] disp_src2_val,
    input  logic [3:0]      disp_src1_tag,
    input  logic [3:0]      disp_src2_tag,
    output logic            disp_ready,
    input  logic            cdb_valid,
    input  logic [3:0]      cdb_tag,
    input  logic [XLEN-1:0] cdb_value,
    output rs_out_t         rs0_data,
    output rs_out_t         rs1_data,
    output rs_out_t         rs2_data,
    output rs_out_t         rs3_data,
    input  logic [3:0]      consumed_bus
);
    localparam int unsigned NUM_ENTRIES = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned TAG_W       = 4;

    typedef struct packed {
        logic             busy;
        logic [2:0]       alu_op;
        logic [TAG_W-1:0] rob_entry;
        logic [1:0]       branch_type;
        logic             src1_rdy;
        logic [XLEN-1:0]  src1_val;
        logic [TAG_W-1:0] src1_tag;
        logic             src2_rdy;
        logic [XLEN-1:0]  src2_val;
        logic [TAG_W-1:0] src2_tag;
    } entry_t;

    entry_t entry_q [NUM_ENTRIES];
    entry_t entry_d [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] busy;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   disp_fire;
    logic                   src1_hit;
    logic                   src2_hit;

    // Busy vector and lowest-indexed free entry, both from current-cycle state.
    always_comb begin
        busy      = '0;
        alloc_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            busy[i] = entry_q[i].busy;
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!entry_q[i].busy) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready = ~&busy;
    assign disp_fire  = disp_valid & disp_ready;
    assign src1_hit   = cdb_valid & (cdb_tag == disp_src1_tag);
    assign src2_hit   = cdb_valid & (cdb_tag == disp_src2_tag);

    // Per-entry next state: wakeup, then consume, then allocation; flush overrides.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_d[i] = entry_q[i];

            if (entry_q[i].busy && cdb_valid) begin
                if (!entry_q[i].src1_rdy && (entry_q[i].src1_tag == cdb_tag)) begin
                    entry_d[i].src1_rdy = 1'b1;
                    entry_d[i].src1_val = cdb_value;
                end
                if (!entry_q[i].src2_rdy && (entry_q[i].src2_tag == cdb_tag)) begin
                    entry_d[i].src2_rdy = 1'b1;
                    entry_d[i].src2_val = cdb_value;
                end
            end

            if (consumed_bus[i]) begin
                entry_d[i].busy = 1'b0;
            end

            // A consumed entry is still busy this cycle, so it is never the alloc target.
            if (disp_fire && (alloc_idx == IDX_W'(i))) begin
                entry_d[i].busy        = 1'b1;
                entry_d[i].alu_op      = disp_ALU_op;
                entry_d[i].rob_entry   = disp_ROB_entry;
                entry_d[i].branch_type = disp_branch_type;
                entry_d[i].src1_tag    = disp_src1_tag;
                entry_d[i].src2_tag    = disp_src2_tag;
                entry_d[i].src1_rdy    = disp_src1_rdy | src1_hit;
                entry_d[i].src2_rdy    = disp_src2_rdy | src2_hit;
                entry_d[i].src1_val    = disp_src1_rdy ? disp_src1_val : cdb_value;
                entry_d[i].src2_val    = disp_src2_rdy ? disp_src2_val : cdb_value;
            end

            if (flush) begin
                entry_d[i] = '0;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Scheduler view; fields of an idle entry are forced to zero.
    function automatic rs_out_t entry_view(input entry_t e);
        rs_out_t o;
        o = '0;
        if (e.busy) begin
            o.valid_operands = e.src1_rdy & e.src2_rdy;
            o.ALU_op         = e.alu_op;
            o.ROB_entry      = e.rob_entry;
            o.branch_type    = e.branch_type;
            o.rs1            = RS_XLEN'(e.src1_val);
            o.rs2            = RS_XLEN'(e.src2_val);
        end
        return o;
    endfunction

    assign rs0_data = entry_view(entry_q[0]);
    assign rs1_data = entry_view(entry_q[1]);
    assign rs2_data = entry_view(entry_q[2]);
    assign rs3_data = entry_view(entry_q[3]);

endmodule

// File: tb/tb_reservation_station.sv
`timescale 1ns/1ps
// Directed bench for reservation_station: dispatch, wakeup, bypass, full/free,
// flush and reset behaviour with hand-computed expected entry views.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, disp_valid;
    logic [2:0]  disp_ALU_op;
    logic [3:0]  disp_ROB_entry;
    logic [1:0]  disp_branch_type;
    logic        disp_src1_rdy, disp_src2_rdy;
    logic [31:0] disp_src1_val, disp_src2_val;
    logic [3:0]  disp_src1_tag, disp_src2_tag;
    logic        disp_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    rs_out_t     rs0_data, rs1_data, rs2_data, rs3_data;
    logic [3:0]  consumed_bus;

    int n_cmp = 0;
    int n_err = 0;

    reservation_station #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ALU_op(disp_ALU_op),
        .disp_ROB_entry(disp_ROB_entry), .disp_branch_type(disp_branch_type),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_ready(disp_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs0_data(rs0_data), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .rs3_data(rs3_data),
        .consumed_bus(consumed_bus)
    );

    always #5 clk = ~clk;

    function automatic rs_out_t mk(input logic v, input logic [2:0] op, input logic [3:0] rob,
                                   input logic [1:0] br, input logic [31:0] a, input logic [31:0] b);
        rs_out_t o;
        o.valid_operands = v;
        o.ALU_op         = op;
        o.ROB_entry      = rob;
        o.branch_type    = br;
        o.rs1            = a;
        o.rs2            = b;
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are checked 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [2:0] op, input logic [3:0] rob, input logic [1:0] br,
                              input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                              input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        disp_valid       = 1'b1;
        disp_ALU_op      = op;
        disp_ROB_entry   = rob;
        disp_branch_type = br;
        disp_src1_rdy    = r1;
        disp_src1_val    = v1;
        disp_src1_tag    = t1;
        disp_src2_rdy    = r2;
        disp_src2_val    = v2;
        disp_src2_tag    = t2;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; disp_valid = 1'b0; disp_ALU_op = '0; disp_ROB_entry = '0;
        disp_branch_type = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        disp_src1_val = '0; disp_src2_val = '0; disp_src1_tag = '0; disp_src2_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; consumed_bus = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("rst_rs0", rs0_data, '0);
        check("rst_rs1", rs1_data, '0);
        check("rst_rs2", rs2_data, '0);
        check("rst_rs3", rs3_data, '0);
        check("rst_ready", disp_ready, 1'b1);

        // Both sources ready: valid one cycle after dispatch.
        drive_disp(3'b000, 4'd5, 2'd0, 1'b1, 32'd7, 4'd0, 1'b1, 32'd9, 4'd0);
        tick();
        idle_inputs();
        check("disp_rdy_rs0", rs0_data, mk(1'b1, 3'b000, 4'd5, 2'd0, 32'd7, 32'd9));
        check("disp_rdy_ready", disp_ready, 1'b1);

        consumed_bus = 4'b0001;
        tick();
        idle_inputs();
        check("consume0", rs0_data, '0);

        // src2 pending on tag 3, broadcast two cycles later.
        drive_disp(3'b010, 4'd1, 2'd1, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd3);
        tick();
        idle_inputs();
        check("wait_c1", rs0_data, mk(1'b0, 3'b010, 4'd1, 2'd1, 32'd1, 32'd0));
        tick();
        check("wait_c2", rs0_data.valid_operands, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hDEAD;
        #2;
        check("wait_bcast_cycle", rs0_data.valid_operands, 1'b0);
        tick();
        idle_inputs();
        check("wakeup", rs0_data, mk(1'b1, 3'b010, 4'd1, 2'd1, 32'd1, 32'hDEAD));

        // Same-cycle bypass into entry 1.
        drive_disp(3'b011, 4'd2, 2'd2, 1'b0, 32'd0, 4'd6, 1'b1, 32'd5, 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'd42;
        tick();
        idle_inputs();
        check("bypass", rs1_data, mk(1'b1, 3'b011, 4'd2, 2'd2, 32'd42, 32'd5));

        // Fill entries 2 and 3 with operands pending on tag 9.
        drive_disp(3'b100, 4'd3, 2'd0, 1'b0, 32'd0, 4'd9, 1'b1, 32'd8, 4'd0);
        tick();
        drive_disp(3'b101, 4'd4, 2'd3, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd9);
        tick();
        idle_inputs();
        check("full_ready", disp_ready, 1'b0);
        check("fill_rs2", rs2_data, mk(1'b0, 3'b100, 4'd3, 2'd0, 32'd0, 32'd8));
        check("fill_rs3", rs3_data, mk(1'b0, 3'b101, 4'd4, 2'd3, 32'd0, 32'd0));

        // Fifth dispatch ignored while full; consume entry 2 in the same cycle.
        drive_disp(3'b111, 4'd7, 2'd1, 1'b1, 32'd70, 4'd0, 1'b1, 32'd71, 4'd0);
        consumed_bus = 4'b0100;
        tick();
        idle_inputs();
        check("full_ign_rs0", rs0_data.ROB_entry, 4'd1);
        check("full_ign_rs1", rs1_data.ROB_entry, 4'd2);
        check("full_ign_rs3", rs3_data.ROB_entry, 4'd4);
        check("freed_rs2", rs2_data, '0);
        check("freed_ready", disp_ready, 1'b1);

        drive_disp(3'b001, 4'd8, 2'd0, 1'b1, 32'd11, 4'd0, 1'b1, 32'd12, 4'd0);
        tick();
        idle_inputs();
        check("realloc_rs2", rs2_data, mk(1'b1, 3'b001, 4'd8, 2'd0, 32'd11, 32'd12));
        check("realloc_ready", disp_ready, 1'b0);

        // One broadcast wakes both sources of entry 3.
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'h55;
        tick();
        idle_inputs();
        check("dual_wake", rs3_data, mk(1'b1, 3'b101, 4'd4, 2'd3, 32'h55, 32'h55));

        // Non-one-hot consume frees entries 0 and 1.
        consumed_bus = 4'b0011;
        tick();
        idle_inputs();
        check("multi_free_rs0", rs0_data, '0);
        check("multi_free_rs1", rs1_data, '0);
        check("multi_free_rs2", rs2_data.valid_operands, 1'b1);
        check("multi_free_ready", disp_ready, 1'b1);

        // Entry 0 pending on tag 12; flush with dispatch and CDB hit together.
        drive_disp(3'b010, 4'd9, 2'd0, 1'b0, 32'd0, 4'd12, 1'b1, 32'd3, 4'd0);
        tick();
        idle_inputs();
        check("pre_flush_rs0", rs0_data, mk(1'b0, 3'b010, 4'd9, 2'd0, 32'd0, 32'd3));
        flush = 1'b1;
        drive_disp(3'b110, 4'd10, 2'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'd77;
        tick();
        idle_inputs();
        check("flush_rs0", rs0_data, '0);
        check("flush_rs1", rs1_data, '0);
        check("flush_rs2", rs2_data, '0);
        check("flush_rs3", rs3_data, '0);
        check("flush_ready", disp_ready, 1'b1);

        // Reset while entries wait on tags 13/14, then broadcast those tags.
        drive_disp(3'b000, 4'd13, 2'd0, 1'b0, 32'd0, 4'd13, 1'b1, 32'd4, 4'd0);
        tick();
        drive_disp(3'b000, 4'd14, 2'd0, 1'b1, 32'd6, 4'd0, 1'b0, 32'd0, 4'd14);
        tick();
        idle_inputs();
        check("pre_rst_rs1", rs1_data, mk(1'b0, 3'b000, 4'd14, 2'd0, 32'd6, 32'd0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_value = 32'd100;
        tick();
        cdb_tag = 4'd14; cdb_value = 32'd200;
        tick();
        idle_inputs();
        check("post_rst_rs0", rs0_data, '0);
        check("post_rst_rs1", rs1_data, '0);
        check("post_rst_ready", disp_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
